bfp_converter: RTL and testbench

Upstream feeder for the vector dot-product stage: accepts one V-element vector of sign/exponent/mantissa floats, P lanes per beat, and buffers all of it. It finds the shared (maximum) exponent, then re-emits the vector P lanes per cycle as aligned two's-complement block-floating-point mantissas. After the last beat it raises a sticky done flag together with the shared exponent. Its outputs map one-to-one onto one operand port set of the dot-product stage (mantissa lanes, lane-ready, previous-module-done, exponent); two instances feed the two operands.

---
 rtl/bfp_converter.sv | 164 ++++++++++++++++
 tb/tb_bfp_converter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bfp_converter.sv
`default_nettype none
// ============================================================================
// Module   : bfp_converter
// Purpose  : Buffers one vector of sign/exponent/fraction floats, finds the
//            shared maximum exponent and re-emits aligned two's-complement
//            block-floating-point mantissas, P lanes per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module bfp_converter #(
    parameter int V    = 8,
    parameter int P    = 4,
    parameter int BIT  = 16,
    parameter int FPM  = 10,
    parameter int BFPM = 7
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [P-1:0][BIT-1:0]          in_floats,
    output logic                           in_ready,
    output logic [P-1:0][BFPM+1:0]         outvals,
    output logic                           outvals_rdy,
    output logic                           done,
    output logic [BIT-FPM-2:0]             outExp
);

    localparam int c_e   = BIT - FPM - 1;
    localparam int c_nb  = V / P;
    localparam int c_cw  = (c_nb > 1) ? $clog2(c_nb) : 1;
    // Buffered word keeps only sign, exponent and the fraction bits that survive.
    localparam int c_sw  = 1 + c_e + BFPM;
    localparam int c_sat = BFPM + 1;

    localparam logic [c_cw-1:0]   c_last = c_cw'(c_nb - 1);
    localparam logic [BFPM+1:0]   c_zero = '0;

    typedef enum logic [0:0] {
        S_LOAD = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t                    r_state;
    logic [c_cw-1:0]           r_cnt;
    logic [c_e-1:0]            r_max;
    logic [c_e-1:0]            r_max_lat;
    logic [c_e-1:0]            r_out_exp;
    logic                      r_in_ready;
    logic                      r_outvals_rdy;
    logic                      r_done;
    logic [P-1:0][BFPM+1:0]    r_outvals;
    logic [P-1:0][c_sw-1:0]    r_buf [c_nb];

    logic [P-1:0][c_sw-1:0]    w_trim;
    logic [P-1:0][BFPM+1:0]    w_conv;
    logic [c_e-1:0]            w_beat_max;
    logic [c_e-1:0]            w_new_max;
    logic                      w_accept;
    logic                      w_unused;

    assign w_unused = ^in_floats;
    assign w_accept = in_valid && r_in_ready;

    always_comb begin
        w_beat_max = '0;
        for (int l = 0; l < P; l++) begin
            if (in_floats[l][BIT-2:FPM] > w_beat_max) begin
                w_beat_max = in_floats[l][BIT-2:FPM];
            end
        end
    end

    // A new vector restarts the maximum from its own first beat.
    assign w_new_max = (r_cnt == '0) ? w_beat_max
                     : ((w_beat_max > r_max) ? w_beat_max : r_max);

    generate
        for (genvar l = 0; l < P; l++) begin : g_lane
            logic [c_sw-1:0]  w_word;
            logic             w_sign;
            logic [c_e-1:0]   w_exp;
            logic [c_e-1:0]   w_d;
            logic [BFPM:0]    w_mag_full;
            logic [BFPM:0]    w_mag;
            logic [BFPM+1:0]  w_ext;

            assign w_trim[l]  = in_floats[l][BIT-1:FPM-BFPM];
            assign w_word     = r_buf[r_cnt][l];
            assign w_sign     = w_word[c_sw-1];
            assign w_exp      = w_word[c_sw-2:BFPM];
            assign w_d        = r_max_lat - w_exp;
            assign w_mag_full = {1'b1, w_word[BFPM-1:0]};
            assign w_mag      = ((w_exp == '0) || (int'(w_d) >= c_sat)) ? '0
                              : (w_mag_full >> w_d);
            assign w_ext      = {1'b0, w_mag};
            assign w_conv[l]  = w_sign ? (c_zero - w_ext) : w_ext;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_LOAD;
            r_cnt         <= '0;
            r_max         <= '0;
            r_max_lat     <= '0;
            r_out_exp     <= '0;
            r_in_ready    <= 1'b0;
            r_outvals_rdy <= 1'b0;
            r_done        <= 1'b0;
            r_outvals     <= '0;
            for (int b = 0; b < c_nb; b++) begin
                r_buf[b] <= '0;
            end
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_outvals_rdy <= 1'b0;
                    r_in_ready    <= 1'b1;
                    // Completion of the previous vector wins over a same-edge
                    // first beat so the downstream stage never misses done.
                    if (r_outvals_rdy) begin
                        r_done    <= 1'b1;
                        r_out_exp <= r_max_lat;
                    end else if (w_accept) begin
                        r_done    <= 1'b0;
                    end
                    if (w_accept) begin
                        r_buf[r_cnt] <= w_trim;
                        r_max        <= w_new_max;
                        if (r_cnt == c_last) begin
                            r_max_lat  <= w_new_max;
                            r_cnt      <= '0;
                            r_in_ready <= 1'b0;
                            r_state    <= S_EMIT;
                        end else begin
                            r_cnt <= r_cnt + c_cw'(1);
                        end
                    end
                end
                S_EMIT: begin
                    r_outvals     <= w_conv;
                    r_outvals_rdy <= 1'b1;
                    if (r_cnt == c_last) begin
                        r_cnt      <= '0;
                        r_in_ready <= 1'b1;
                        r_state    <= S_LOAD;
                    end else begin
                        r_cnt <= r_cnt + c_cw'(1);
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign outvals     = r_outvals;
    assign outvals_rdy = r_outvals_rdy;
    assign done        = r_done;
    assign outExp      = r_out_exp;

endmodule
`default_nettype wire

// File: tb/tb_bfp_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bfp_converter
// Purpose  : Scoreboard bench for bfp_converter with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bfp_converter;

    localparam int V = 8, P = 4, BIT = 16, FPM = 10, BFPM = 7, E = 5;

    typedef logic [P-1:0][BIT-1:0]    fbeat_t;
    typedef logic [P-1:0][BFPM+1:0]   obeat_t;

    logic   clk = 1'b0;
    logic   reset = 1'b0;
    logic   in_valid = 1'b0;
    fbeat_t in_floats = '0;
    logic   in_ready;
    obeat_t outvals;
    logic   outvals_rdy;
    logic   done;
    logic [E-1:0] outExp;

    obeat_t       exp_q[$];
    logic [E-1:0] expo_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   rdy_cnt = 0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    bfp_converter #(.V(V), .P(P), .BIT(BIT), .FPM(FPM), .BFPM(BFPM)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_floats(in_floats),
        .in_ready(in_ready), .outvals(outvals), .outvals_rdy(outvals_rdy),
        .done(done), .outExp(outExp)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every strobe and on every rising done.
    always @(negedge clk) begin
        if (reset && outvals_rdy) begin
            rdy_cnt++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: got %0h, expected no strobe", outvals);
            end else begin
                check("outvals", outvals, exp_q.pop_front());
            end
        end
        if (reset && done && !prev_done) begin
            if (expo_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got outExp %0h, expected no done", outExp);
            end else begin
                check("outExp", outExp, expo_q.pop_front());
            end
        end
        prev_done = done;
    end

    task automatic send_beat(input fbeat_t f, input int gap);
        int k;
        repeat (gap) @(negedge clk);
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        in_floats = f;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done, 1);
    endtask

    fbeat_t a0, a1, s0, c0, c1, zb, junk;
    obeat_t ea0, es0, ec0, ec1, ez;

    initial begin
        a0   = {16'h3E00, 16'hBC00, 16'h3C00, 16'h4000};
        a1   = '0;
        s0   = {16'h0000, 16'h0000, 16'h3C00, 16'h5C00};
        c0   = {16'h0001, 16'h3800, 16'hBE00, 16'h3C00};
        c1   = {16'h2C00, 16'h0000, 16'h0000, 16'h3400};
        zb   = '0;
        junk = {4{16'h7C00}};
        ea0  = {9'h060, 9'h1C0, 9'h040, 9'h080};
        es0  = {9'h000, 9'h000, 9'h000, 9'h080};
        ec0  = {9'h000, 9'h040, 9'h140, 9'h080};
        ec1  = {9'h008, 9'h000, 9'h000, 9'h020};
        ez   = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_outvals_rdy", outvals_rdy, 0);
        check("rst_done", done, 0);
        check("rst_outExp", outExp, 0);
        reset = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);

        // Asynchronous reset while emitting: vector discarded, no strobes
        send_beat(a0, 0);
        send_beat(a1, 0);
        #2 reset = 1'b0;
        #1;
        check("async_rst_in_ready", in_ready, 0);
        check("async_rst_rdy", outvals_rdy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_outvals", outvals, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rdy_cnt = 0;
        repeat (6) @(negedge clk);
        check("post_rst_strobes", rdy_cnt, 0);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_done", done, 0);

        // Basic alignment
        exp_q.push_back(ea0); exp_q.push_back(ez); expo_q.push_back(5'h10);
        rdy_cnt = 0;
        send_beat(a0, 0);
        send_beat(a1, 0);
        wait_done();
        check("basic_strobes", rdy_cnt, 2);

        // Shift saturation
        exp_q.push_back(es0); exp_q.push_back(ez); expo_q.push_back(5'h17);
        send_beat(s0, 0);
        send_beat(zb, 0);
        wait_done();

        // Input stalls between load beats
        exp_q.push_back(ea0); exp_q.push_back(ez); expo_q.push_back(5'h10);
        rdy_cnt = 0;
        send_beat(a0, 0);
        send_beat(a1, 2);
        wait_done();
        check("stall_strobes", rdy_cnt, 2);

        // Back-to-back vector with smaller max; done clears on first accept
        exp_q.push_back(ec0); exp_q.push_back(ec1); expo_q.push_back(5'h0F);
        check("done_held", done, 1);
        send_beat(c0, 0);
        check("done_cleared", done, 0);
        send_beat(c1, 0);
        wait_done();

        // Beats offered during EMIT must be ignored
        exp_q.push_back(ea0); exp_q.push_back(ez); expo_q.push_back(5'h10);
        send_beat(a0, 0);
        send_beat(a1, 0);
        in_floats = junk;
        in_valid  = 1'b1;
        @(negedge clk);
        check("busy_in_ready_0", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("busy_in_ready_1", in_ready, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done();

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("exp_queue_drained", expo_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
